// File: rtl/core_arb_pkg.sv
// Shared types and seven-segment helpers for the core result arbiter.
package core_arb_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    FOUND  = 2'd1,
    FAIL   = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    SEG_MODE_BLANK = 2'd0,
    SEG_MODE_HEX   = 2'd1,
    SEG_MODE_DASH  = 2'd2
  } seg_mode_t;

  localparam logic [6:0] SEG_BLANK   = 7'h7F;
  localparam logic [6:0] SEG_DASH    = 7'h3F;
  localparam int         DISP_DIGITS = 6;

  // Active-low {g,f,e,d,c,b,a} glyphs for 0-F.
  function automatic logic [6:0] nibble_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      default: seg = 7'h0E;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_seg_decoder.sv
// One seven-segment digit: blank, hex glyph, or dash.
module hex_seg_decoder
  import core_arb_pkg::*;
(
  input  logic [3:0] nibble_i,
  input  seg_mode_t  mode_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (mode_i)
      SEG_MODE_HEX:  seg_o = nibble_to_seg(nibble_i);
      SEG_MODE_DASH: seg_o = SEG_DASH;
      default:       seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/core_result_arbiter.sv
// Picks the first decryption core to finish, latches its key, stops the
// others, counts search cycles and drives the status display.
module core_result_arbiter
  import core_arb_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int KEY_WIDTH = 24,
  parameter int CNT_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_CORES-1:0]           core_finish,
  input  logic [NUM_CORES-1:0]           core_exhausted,
  input  logic [NUM_CORES*KEY_WIDTH-1:0] core_key,
  output logic                           outer_finish,
  output logic                           found,
  output logic                           fail,
  output logic [KEY_WIDTH-1:0]           winning_key,
  output logic [2:0]                     winner_index,
  output logic [CNT_WIDTH-1:0]           search_cycles,
  output logic [6:0]                     hex5,
  output logic [6:0]                     hex4,
  output logic [6:0]                     hex3,
  output logic [6:0]                     hex2,
  output logic [6:0]                     hex1,
  output logic [6:0]                     hex0,
  output logic                           led_busy
);

  arb_state_t           state_q, state_d;
  logic [KEY_WIDTH-1:0] key_q,   key_d;
  logic [2:0]           idx_q,   idx_d;
  logic [CNT_WIDTH-1:0] cnt_q,   cnt_d;

  logic                 any_fin;
  logic [2:0]           fin_idx;
  logic [KEY_WIDTH-1:0] fin_key;

  // Descending scan so the lowest set index is the one left standing.
  always_comb begin
    fin_idx = '0;
    fin_key = '0;
    for (int i = NUM_CORES-1; i >= 0; i--) begin
      if (core_finish[i]) begin
        fin_idx = 3'(i);
        fin_key = core_key[i*KEY_WIDTH +: KEY_WIDTH];
      end
    end
  end

  assign any_fin = |core_finish;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      SEARCH: begin
        cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        if (any_fin) begin
          state_d = FOUND;
          key_d   = fin_key;
          idx_d   = fin_idx;
        end else if (&core_exhausted) begin
          state_d = FAIL;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SEARCH;
      key_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  assign outer_finish  = (state_q != SEARCH);
  assign found         = (state_q == FOUND);
  assign fail          = (state_q == FAIL);
  assign led_busy      = (state_q == SEARCH);
  assign winning_key   = key_q;
  assign winner_index  = idx_q;
  assign search_cycles = cnt_q;

  // Display always shows six nibbles; narrower keys are zero-padded.
  logic [4*DISP_DIGITS-1:0]       disp_key;
  seg_mode_t                      seg_mode;
  logic [DISP_DIGITS-1:0][6:0]    seg;

  assign disp_key = (4*DISP_DIGITS)'(key_q);

  always_comb begin
    seg_mode = SEG_MODE_BLANK;
    case (state_q)
      FOUND:   seg_mode = SEG_MODE_HEX;
      FAIL:    seg_mode = SEG_MODE_DASH;
      default: seg_mode = SEG_MODE_BLANK;
    endcase
  end

  for (genvar g = 0; g < DISP_DIGITS; g++) begin : g_dig
    hex_seg_decoder u_dec (
      .nibble_i (disp_key[4*g +: 4]),
      .mode_i   (seg_mode),
      .seg_o    (seg[g])
    );
  end

  assign hex0 = seg[0];
  assign hex1 = seg[1];
  assign hex2 = seg[2];
  assign hex3 = seg[3];
  assign hex4 = seg[4];
  assign hex5 = seg[5];

endmodule

// File: tb/tb_core_result_arbiter.sv
// Bench for core_result_arbiter: vector table, corner sequences and a
// randomized run against an edge-level behavioural model.
module tb_core_result_arbiter;

  localparam int NC = 4;
  localparam int KW = 24;
  localparam int CW = 32;

  localparam logic [6:0] HEXTAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NC-1:0]        fin, exh;
  logic [NC-1:0][KW-1:0] keys;

  logic          outer_finish, found, fail, led_busy;
  logic [KW-1:0] winning_key;
  logic [2:0]    winner_index;
  logic [CW-1:0] search_cycles;
  logic [6:0]    hex5, hex4, hex3, hex2, hex1, hex0;
  logic [5:0][6:0] hexv;

  // Narrow-counter instance to exercise saturation; it never leaves SEARCH.
  logic       s_fin = 1'b0, s_exh = 1'b0;
  logic [7:0] s_key = 8'h00;
  logic       s_outer, s_found, s_fail, s_busy;
  logic [7:0] s_wkey;
  logic [2:0] s_widx;
  logic [3:0] s_cnt;
  logic [6:0] s_h5, s_h4, s_h3, s_h2, s_h1, s_h0;

  always #5 clk = ~clk;

  core_result_arbiter #(.NUM_CORES(NC), .KEY_WIDTH(KW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .core_finish(fin), .core_exhausted(exh), .core_key(keys),
    .outer_finish(outer_finish), .found(found), .fail(fail), .winning_key(winning_key),
    .winner_index(winner_index), .search_cycles(search_cycles),
    .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
    .led_busy(led_busy));

  core_result_arbiter #(.NUM_CORES(1), .KEY_WIDTH(8), .CNT_WIDTH(4)) dut_sat (
    .clk(clk), .reset_n(reset_n), .core_finish(s_fin), .core_exhausted(s_exh), .core_key(s_key),
    .outer_finish(s_outer), .found(s_found), .fail(s_fail), .winning_key(s_wkey),
    .winner_index(s_widx), .search_cycles(s_cnt),
    .hex5(s_h5), .hex4(s_h4), .hex3(s_h3), .hex2(s_h2), .hex1(s_h1), .hex0(s_h0),
    .led_busy(s_busy));

  assign hexv = {hex5, hex4, hex3, hex2, hex1, hex0};

  int checks = 0;
  int errors = 0;

  // Behavioural model: outcome flags plus counts of edges seen.
  bit            m_found, m_fail;
  logic [2:0]    m_idx;
  logic [KW-1:0] m_key;
  logic [CW-1:0] m_cnt;
  int            m_edges;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    m_found = 0; m_fail = 0; m_idx = '0; m_key = '0; m_cnt = '0; m_edges = 0;
  endtask

  task automatic step();
    int w;
    m_edges++;
    if (!m_found && !m_fail) begin
      if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1;
      w = -1;
      for (int i = 0; i < NC; i++) if (w < 0 && fin[i]) w = i;
      if (w >= 0) begin
        m_found = 1; m_idx = 3'(w); m_key = keys[w];
      end else if (exh == {NC{1'b1}}) begin
        m_fail = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [5:0][6:0] eh;
    for (int k = 0; k < 6; k++)
      eh[k] = m_found ? HEXTAB[m_key[4*k +: 4]] : (m_fail ? 7'h3F : 7'h7F);
    chk({tag, ".outer"},  64'(outer_finish),  64'(m_found | m_fail));
    chk({tag, ".found"},  64'(found),         64'(m_found));
    chk({tag, ".fail"},   64'(fail),          64'(m_fail));
    chk({tag, ".idx"},    64'(winner_index),  64'(m_idx));
    chk({tag, ".key"},    64'(winning_key),   64'(m_key));
    chk({tag, ".cnt"},    64'(search_cycles), 64'(m_cnt));
    chk({tag, ".busy"},   64'(led_busy),      64'(!(m_found | m_fail)));
    chk({tag, ".hex"},    64'(hexv),          64'(eh));
    chk({tag, ".satcnt"}, 64'(s_cnt),         64'((m_edges > 15) ? 15 : m_edges));
  endtask

  task automatic do_reset(input string tag);
    fin = '0; exh = '0; keys = '0;
    reset_n = 1'b0;
    model_clear();
    #1;
    check_all({tag, ".rst"});
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  typedef struct {
    int              idle;
    logic [3:0]      exh_pre;
    logic [3:0]      fin;
    logic [3:0]      exh;
    logic [3:0][23:0] k;
    bit              e_found;
    bit              e_fail;
    logic [2:0]      e_idx;
    logic [23:0]     e_key;
  } vec_t;

  vec_t vt [5];

  initial begin
    reset_n = 1'b0;
    fin = '0; exh = '0; keys = '0;

    vt[0] = '{49, 4'b0000, 4'b0100, 4'b0000, {24'h0, 24'h00F0A3, 24'h0, 24'h0}, 1, 0, 3'd2, 24'h00F0A3};
    vt[1] = '{10, 4'b0000, 4'b1010, 4'b0000, {24'hABCDEF, 24'h0, 24'h123456, 24'h0}, 1, 0, 3'd1, 24'h123456};
    vt[2] = '{7,  4'b1110, 4'b0001, 4'b1111, {24'h1, 24'h2, 24'h3, 24'h000777}, 1, 0, 3'd0, 24'h000777};
    vt[3] = '{5,  4'b0111, 4'b0000, 4'b1111, {24'h9, 24'h8, 24'h7, 24'h6}, 0, 1, 3'd0, 24'h0};
    vt[4] = '{0,  4'b0000, 4'b1000, 4'b0000, {24'hFEDCBA, 24'h1, 24'h2, 24'h3}, 1, 0, 3'd3, 24'hFEDCBA};

    // Idle search: counter runs, display blank, narrow counter saturates.
    do_reset("idle");
    repeat (10) step();
    check_all("idle10");
    repeat (90) step();
    check_all("idle100");
    chk("idle100.cnt_const", 64'(search_cycles), 64'd100);
    chk("idle100.sat_const", 64'(s_cnt), 64'd15);

    for (int r = 0; r < 5; r++) begin
      do_reset($sformatf("vec%0d", r));
      exh = vt[r].exh_pre;
      repeat (vt[r].idle) step();
      fin = vt[r].fin; exh = vt[r].exh; keys = vt[r].k;
      step();
      check_all($sformatf("vec%0d", r));
      chk($sformatf("vec%0d.tfound", r), 64'(found), 64'(vt[r].e_found));
      chk($sformatf("vec%0d.tfail", r),  64'(fail),  64'(vt[r].e_fail));
      chk($sformatf("vec%0d.tidx", r),   64'(winner_index), 64'(vt[r].e_idx));
      chk($sformatf("vec%0d.tkey", r),   64'(winning_key),  64'(vt[r].e_key));
      chk($sformatf("vec%0d.tcnt", r),   64'(search_cycles), 64'(vt[r].idle + 1));
      fin = 4'hF; exh = 4'hF; keys = {24'h111111, 24'h222222, 24'h333333, 24'h444444};
      repeat (3) step();
      check_all($sformatf("vec%0d.hold", r));
    end
    do_reset("hexchk");
    keys[2] = 24'h00F0A3; fin = 4'b0100;
    step();
    chk("hex.const", 64'(hexv), 64'({7'h40, 7'h40, 7'h0E, 7'h40, 7'h08, 7'h30}));

    // Exhaustion one core at a time, then a late finish is ignored.
    do_reset("exh");
    for (int b = 0; b < 4; b++) begin
      exh[b] = 1'b1;
      step();
      check_all($sformatf("exh%0d", b));
    end
    chk("exh.dash", 64'(hexv), 64'({6{7'h3F}}));
    fin = 4'b0001; keys[0] = 24'h5A5A5A;
    step();
    check_all("exh.late");

    // Second core finishing a cycle after the first changes nothing.
    do_reset("second");
    keys[3] = 24'hC0FFEE; fin = 4'b1000;
    step();
    check_all("second.a");
    fin = 4'b1001; keys[0] = 24'h000001;
    step();
    check_all("second.b");

    // Asynchronous reset mid-search and in FOUND.
    do_reset("amid");
    repeat (20) step();
    check_all("amid.pre");
    reset_n = 1'b0;
    model_clear();
    #1;
    check_all("amid.async");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) step();
    check_all("amid.restart");
    fin = 4'b0010; keys[1] = 24'hBEEF01;
    step();
    check_all("afound.pre");
    reset_n = 1'b0;
    fin = '0;
    model_clear();
    #1;
    check_all("afound.async");
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) step();
    check_all("afound.restart");

    // Randomized level-held finishes and exhaustion against the model.
    for (int t = 0; t < 40; t++) begin
      do_reset($sformatf("rnd%0d", t));
      for (int c = 0; c < 50; c++) begin
        if ($urandom_range(0, 11) == 0) fin[$urandom_range(0, NC-1)] = 1'b1;
        if ($urandom_range(0, 3) == 0) exh[$urandom_range(0, NC-1)] = 1'b1;
        for (int i = 0; i < NC; i++) keys[i] = KW'($urandom);
        step();
        check_all($sformatf("rnd%0d.c%0d", t, c));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
